// File: rtl/inst_fetch_queue_pkg.sv
// Shared decode definitions for the fetch queue: entry layout and opcode forming.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package inst_fetch_queue_pkg;

    // Primary opcode that selects the funct-extended (R-type) opcode form
    localparam logic [5:0] OP_SPECIAL = 6'd0;

    // One queued, pre-decoded instruction; pc sits in the low 32 bits
    typedef struct packed {
        logic [11:0] opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] immediate;
        logic [25:0] address;
        logic [31:0] pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // R-type instructions carry funct in the low opcode bits; everything else pads with zero
    function automatic logic [11:0] opcode_form(input logic [31:0] inst);
        logic [11:0] op;
        if (inst[31:26] == OP_SPECIAL) begin
            op = {inst[31:26], inst[5:0]};
        end else begin
            op = {inst[31:26], 6'd0};
        end
        return op;
    endfunction

    function automatic entry_t decode_inst(input logic [31:0] inst, input logic [31:0] inst_pc);
        entry_t e;
        e.opcode    = opcode_form(inst);
        e.rs        = inst[25:21];
        e.rt        = inst[20:16];
        e.rd        = inst[15:11];
        e.shamt     = inst[10:6];
        e.immediate = inst[15:0];
        e.address   = inst[25:0];
        e.pc        = inst_pc;
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous clear.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: writes when full are accepted only together with a read; clr beats both.
module inst_fetch_queue_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, push, pop;

    // Handshake decode and pointer/count update; pointers wrap naturally
    always_comb begin
        full     = (count_q == DEPTH[AW:0]);
        empty    = (count_q == '0);
        pop      = rd_rdy && !empty;
        push     = wr_vld && (!full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset; its contents are only observed behind rd_vld
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_vld = !empty;
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC owner: issues credited reads to a 1-cycle imem, decodes responses into a DEPTH-entry queue.
// Latency: mem_req to out_valid is 2 cycles; redirect empties the queue by the next cycle.
// Backpressure: fetch issues only while queued + in-flight < DEPTH; head is held while !deq_ready.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter int          MEM_BITS = 11,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [MEM_BITS-1:0]    mem_addr,
    output logic                   mem_req,
    input  logic [31:0]            mem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   deq_ready,
    output logic                   out_valid,
    output logic [11:0]            opcode,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             shamt,
    output logic [15:0]            immediate,
    output logic [25:0]            address,
    output logic [31:0]            pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               epoch_q, epoch_d;
    logic               resp_vld_q, resp_vld_d;
    logic               resp_epoch_q, resp_epoch_d;
    logic [31:0]        resp_pc_q, resp_pc_d;

    logic               pc_legal;
    logic [CW:0]        occ;
    logic               enq_vld;
    entry_t             enq_dat;
    entry_t             head;
    logic [ENTRY_W-1:0] head_dat;
    logic               fifo_vld;
    logic [CW-1:0]      fifo_count;

    // Request gate: legal PC, a free credit, no redirect, and never while reset is held
    always_comb begin
        pc_legal = ((fetch_pc_q >> MEM_BITS) == 32'd0);
        occ      = {1'b0, fifo_count} + {{CW{1'b0}}, resp_vld_q};
        mem_req  = rst && !redirect_valid && pc_legal && (occ < DEPTH_OCC);
        mem_addr = fetch_pc_q[MEM_BITS-1:0];
    end

    // Next fetch PC, epoch and response tag; a redirect overrides the increment
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (mem_req) begin
            fetch_pc_d = fetch_pc_q + 32'd1;
        end
        epoch_d      = epoch_q ^ redirect_valid;
        resp_vld_d   = mem_req;
        resp_pc_d    = mem_req ? fetch_pc_q : resp_pc_q;
        resp_epoch_d = epoch_q;
    end

    // Response enqueue: current-epoch only, and never in a redirect cycle
    always_comb begin
        enq_vld = resp_vld_q && (resp_epoch_q == epoch_q) && !redirect_valid;
        enq_dat = decode_inst(mem_rdata, resp_pc_q);
    end

    // Fetch state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            epoch_q      <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_epoch_q <= 1'b0;
            resp_pc_q    <= 32'd0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            epoch_q      <= epoch_d;
            resp_vld_q   <= resp_vld_d;
            resp_epoch_q <= resp_epoch_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

    inst_fetch_queue_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (redirect_valid),
        .wr_vld (enq_vld),
        .wr_dat (enq_dat),
        .rd_rdy (deq_ready),
        .rd_vld (fifo_vld),
        .rd_dat (head_dat),
        .count  (fifo_count)
    );

    // Head fields are forced to zero whenever the queue is empty
    always_comb begin
        head      = entry_t'(head_dat);
        out_valid = fifo_vld;
        opcode    = fifo_vld ? head.opcode    : 12'd0;
        rs        = fifo_vld ? head.rs        : 5'd0;
        rt        = fifo_vld ? head.rt        : 5'd0;
        rd        = fifo_vld ? head.rd        : 5'd0;
        shamt     = fifo_vld ? head.shamt     : 5'd0;
        immediate = fifo_vld ? head.immediate : 16'd0;
        address   = fifo_vld ? head.address   : 26'd0;
        pc        = fifo_vld ? head.pc        : 32'd0;
        count     = fifo_count;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic [10:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        deq_ready = 1'b0;
    logic        out_valid;
    logic [11:0] opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [31:0] pc;
    logic [3:0]  count;

    // Second instance starting near the top of memory
    logic [10:0] mem_addr_h;
    logic        mem_req_h;
    logic [31:0] mem_rdata_h = 32'd0;
    logic        redirect_valid_h = 1'b0;
    logic [31:0] redirect_pc_h = 32'd0;
    logic        deq_ready_h = 1'b0;
    logic        out_valid_h;
    logic [11:0] opcode_h;
    logic [4:0]  rs_h, rt_h, rd_h, shamt_h;
    logic [15:0] immediate_h;
    logic [25:0] address_h;
    logic [31:0] pc_h;
    logic [3:0]  count_h;

    inst_fetch_queue #(.DEPTH(8), .MEM_BITS(11), .RESET_PC(32'd0)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
        .out_valid(out_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .immediate(immediate), .address(address), .pc(pc), .count(count)
    );

    inst_fetch_queue #(.DEPTH(8), .MEM_BITS(11), .RESET_PC(32'd2046)) u_dut_h (
        .clk(clk), .rst(rst), .mem_addr(mem_addr_h), .mem_req(mem_req_h), .mem_rdata(mem_rdata_h),
        .redirect_valid(redirect_valid_h), .redirect_pc(redirect_pc_h), .deq_ready(deq_ready_h),
        .out_valid(out_valid_h), .opcode(opcode_h), .rs(rs_h), .rt(rt_h), .rd(rd_h), .shamt(shamt_h),
        .immediate(immediate_h), .address(address_h), .pc(pc_h), .count(count_h)
    );

    // Instruction memory: word 0 and 1 are hand-picked, others are "lw" with imm = address
    logic [31:0] imem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) imem[i] = {6'h23, 10'd0, i[15:0]};
        imem[0] = 32'h0022_1020;
        imem[1] = 32'h8C41_0004;
    end

    // Synchronous read, one cycle latency
    always @(posedge clk) begin
        if (mem_req)   mem_rdata   <= imem[mem_addr];
        if (mem_req_h) mem_rdata_h <= imem[mem_addr_h];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_ov(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ov_h(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (out_valid_h) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          rst_first;
        bit          deq;
        bit          ov;
        logic [31:0] pc;
        logic [3:0]  cnt;
        bit          mreq;
        logic [11:0] op;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [25:0] addr;
    } vec_t;

    vec_t vt[$];

    // Hand-decoded head fields for the words loaded into imem
    task automatic addv(input bit rf, input bit dq, input bit ov, input logic [31:0] p,
                        input logic [3:0] c, input bit mr);
        vec_t v;
        v.rst_first = rf; v.deq = dq; v.ov = ov; v.cnt = c; v.mreq = mr;
        v.pc = ov ? p : 32'd0;
        if (!ov) begin
            v.op = 12'h000; v.imm = 16'h0000; v.rs = 5'd0; v.addr = 26'd0;
        end else if (p == 32'd0) begin
            v.op = 12'h020; v.imm = 16'h1020; v.rs = 5'd1; v.addr = 26'h0221020;
        end else if (p == 32'd1) begin
            v.op = 12'h8C0; v.imm = 16'h0004; v.rs = 5'd2; v.addr = 26'h0410004;
        end else begin
            v.op = 12'h8C0; v.imm = p[15:0]; v.rs = 5'd0; v.addr = p[25:0];
        end
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit          ok;
        int          exp_pc;
        int          n_req;
        logic [31:0] dlv[$];

        // Reset state, both instances, while reset is held
        #12;
        chk("rst out_valid", out_valid, 0);
        chk("rst mem_req",   mem_req,   0);
        chk("rst count",     count,     0);
        chk("rst opcode",    opcode,    0);
        chk("rst pc",        pc,        0);
        chk("rst mem_req_h", mem_req_h, 0);
        chk("rst count_h",   count_h,   0);

        // Streaming with deq_ready=1: first delivery at cycle 2
        addv(1, 1, 0, 0, 0, 1);
        addv(0, 1, 0, 0, 0, 1);
        addv(0, 1, 1, 0, 1, 1);
        addv(0, 1, 1, 1, 1, 1);
        addv(0, 1, 1, 2, 1, 1);
        // Fill with deq_ready=0: 8 requests, then stall with head pc 0 held
        addv(1, 0, 0, 0, 0, 1);
        addv(0, 0, 0, 0, 0, 1);
        for (int k = 2; k <= 7; k++) addv(0, 0, 1, 0, 4'(k - 1), 1);
        addv(0, 0, 1, 0, 7, 0);
        addv(0, 0, 1, 0, 8, 0);
        addv(0, 0, 1, 0, 8, 0);
        addv(0, 0, 1, 0, 8, 0);
        // One dequeue from full: 8 -> 7 -> 8 with exactly one new request
        addv(0, 1, 1, 0, 8, 0);
        addv(0, 0, 1, 1, 7, 1);
        addv(0, 0, 1, 1, 7, 0);
        addv(0, 0, 1, 1, 8, 0);

        foreach (vt[i]) begin
            if (vt[i].rst_first) do_reset();
            deq_ready = vt[i].deq;
            #1;
            chk($sformatf("v%0d out_valid", i), out_valid, vt[i].ov);
            chk($sformatf("v%0d pc", i),        pc,        vt[i].pc);
            chk($sformatf("v%0d count", i),     count,     vt[i].cnt);
            chk($sformatf("v%0d mem_req", i),   mem_req,   vt[i].mreq);
            chk($sformatf("v%0d opcode", i),    opcode,    vt[i].op);
            chk($sformatf("v%0d immediate", i), immediate, vt[i].imm);
            chk($sformatf("v%0d rs", i),        rs,        vt[i].rs);
            chk($sformatf("v%0d address", i),   address,   vt[i].addr);
            @(posedge clk); #1;
        end

        // Drain: pcs must continue 1, 2, ... with no loss or duplication
        deq_ready = 1'b1;
        exp_pc = 1;
        for (int k = 0; k < 60 && exp_pc <= 12; k++) begin
            if (out_valid) begin
                chk("drain pc", pc, exp_pc);
                exp_pc++;
            end
            @(posedge clk); #1;
        end
        chk("drain delivered", exp_pc, 13);

        // Redirect with 3 queued and 1 in flight
        do_reset();
        deq_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("redir pre count", count, 3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd100;
        #1;
        chk("redir cycle mem_req", mem_req, 0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        chk("redir next count",     count,     0);
        chk("redir next out_valid", out_valid, 0);
        chk("redir next mem_req",   mem_req,   1);
        chk("redir next mem_addr",  mem_addr,  100);
        deq_ready = 1'b1;
        wait_ov(10, ok);
        chk("redir wait", ok, 1);
        chk("redir first pc",  pc,        100);
        chk("redir first imm", immediate, 100);
        @(posedge clk); #1;
        chk("redir second pc", pc, 101);

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'd200;
        @(posedge clk); #1;
        redirect_pc    = 32'd300;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_ov(10, ok);
        chk("b2b wait", ok, 1);
        chk("b2b first pc", pc, 300);

        // Fetch near the top of memory stops after two words
        do_reset();
        deq_ready_h = 1'b1;
        n_req = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (mem_req_h) n_req++;
            if (out_valid_h) dlv.push_back(pc_h);
            @(posedge clk);
        end
        #1;
        chk("top req pulses", n_req, 2);
        chk("top delivered",  dlv.size(), 2);
        if (dlv.size() == 2) begin
            chk("top pc0", dlv[0], 2046);
            chk("top pc1", dlv[1], 2047);
        end
        chk("top mem_req idle", mem_req_h,   0);
        chk("top out_valid",    out_valid_h, 0);
        redirect_valid_h = 1'b1;
        redirect_pc_h    = 32'd5;
        @(posedge clk); #1;
        redirect_valid_h = 1'b0;
        wait_ov_h(10, ok);
        chk("top resume wait", ok, 1);
        chk("top resume pc",   pc_h, 5);
        deq_ready_h = 1'b0;

        // Asynchronous reset mid-stream with 4 entries queued
        do_reset();
        deq_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst pre count", count, 4);
        #2;
        rst = 1'b0;
        #1;
        chk("arst out_valid", out_valid, 0);
        chk("arst count",     count,     0);
        chk("arst mem_req",   mem_req,   0);
        chk("arst pc",        pc,        0);
        @(negedge clk);
        rst = 1'b1;
        deq_ready = 1'b1;
        wait_ov(10, ok);
        chk("arst restart wait", ok, 1);
        chk("arst restart pc",   pc, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
